// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The slave side is the adder; the master side feeds operands and takes results.
interface pipelined_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid, a, b, carry_in, sub, out_ready,
        input  in_ready, out_valid, sum, carry, overflow
    );

    modport slave (
        input  in_valid, a, b, carry_in, sub, out_ready,
        output in_ready, out_valid, sum, carry, overflow
    );
endinterface

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract split into STAGES carry-chained chunks, one chunk per
// register stage, with a valid/ready pipeline that freezes as a whole on stall.
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    pipelined_adder_if.slave bus
);
    localparam int CHUNK = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_adder: STAGES must divide WIDTH and lie in 1..WIDTH");
    end

    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             cy_q  [STAGES];
    logic             vld_q [STAGES];
    logic             ovf_q;

    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic             cy_d  [STAGES];
    logic             vld_d [STAGES];
    logic             ovf_d;

    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] s_in   [STAGES];
    logic             cy_in  [STAGES];
    logic             vld_in [STAGES];
    logic [CHUNK:0]   part   [STAGES];

    logic advance;

    // A full output slot that nobody takes freezes every stage, so bubbles stay in place.
    assign advance = !(vld_q[STAGES-1] && !bus.out_ready);

    always_comb begin
        // Subtraction is a + ~b + 1; carry_in is irrelevant then.
        a_in[0]   = bus.a;
        b_in[0]   = bus.sub ? ~bus.b : bus.b;
        cy_in[0]  = bus.sub | bus.carry_in;
        s_in[0]   = '0;
        vld_in[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k]   = a_q[k-1];
            b_in[k]   = b_q[k-1];
            cy_in[k]  = cy_q[k-1];
            s_in[k]   = s_q[k-1];
            vld_in[k] = vld_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            part[k] = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
                    + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, cy_in[k]};
            a_d[k]   = a_in[k];
            b_d[k]   = b_in[k];
            s_d[k]   = s_in[k];
            s_d[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
            cy_d[k]  = part[k][CHUNK];
            vld_d[k] = vld_in[k];
        end

        // Same-sign operands giving an opposite-sign result is exactly carry-in(MSB) ^ carry-out(MSB).
        ovf_d = (a_in[STAGES-1][WIDTH-1] == b_in[STAGES-1][WIDTH-1])
             && (s_d[STAGES-1][WIDTH-1] != a_in[STAGES-1][WIDTH-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                cy_q[k]  <= 1'b0;
                vld_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                s_q[k]   <= s_d[k];
                cy_q[k]  <= cy_d[k];
                vld_q[k] <= vld_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.sum       = s_q[STAGES-1];
    assign bus.carry     = cy_q[STAGES-1];
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed scenarios on STAGES=2, then shared random
// traffic into STAGES=1,2,4,8 instances checked against an arithmetic reference.
module tb_pipelined_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, carry_in, sub, out_ready;
    logic [W-1:0] a, b;

    logic [3:0]        ir, ov, cy, of;
    logic [3:0][W-1:0] sm;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W+1:0] exq [4][$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        pipelined_adder_if #(.WIDTH(W)) u_if ();
        assign u_if.in_valid  = in_valid;
        assign u_if.a         = a;
        assign u_if.b         = b;
        assign u_if.carry_in  = carry_in;
        assign u_if.sub       = sub;
        assign u_if.out_ready = out_ready;
        assign ir[gi] = u_if.in_ready;
        assign ov[gi] = u_if.out_valid;
        assign sm[gi] = u_if.sum;
        assign cy[gi] = u_if.carry;
        assign of[gi] = u_if.overflow;

        pipelined_adder #(.WIDTH(W), .STAGES(1 << gi)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_if.slave)
        );
    end

    // Reference: plain integer arithmetic, result packed as {overflow, carry, sum}.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic ci, input logic s);
        int ux, uy, sx, sy, full, sres;
        logic c, o;
        logic [W-1:0] r;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            full = ux - uy;
            c    = (ux >= uy);
            sres = sx - sy;
        end else begin
            full = ux + uy + int'(ci);
            c    = (full >= (1 << W));
            sres = sx + sy + int'(ci);
        end
        r = W'(full & ((1 << W) - 1));
        o = (sres > (1 << (W-1)) - 1) || (sres < -(1 << (W-1)));
        return {o, c, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [W-1:0] s, input logic c, input logic o);
        chk({tag, "_vld"}, 32'(ov[1]), 32'd1);
        chk({tag, "_res"}, 32'({of[1], cy[1], sm[1]}), 32'({o, c, s}));
    endtask

    task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic s);
        in_valid = v;
        a        = x;
        b        = y;
        carry_in = ci;
        sub      = s;
    endtask

    initial begin
        logic [W+1:0] e;
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);

        // Reset state on every instance
        @(negedge clk);
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_vld%0d", i), 32'(ov[i]), 32'd0);
            chk($sformatf("rst_sum%0d", i), 32'(sm[i]), 32'd0);
            chk($sformatf("rst_cy%0d", i),  32'(cy[i]), 32'd0);
            chk($sformatf("rst_ovf%0d", i), 32'(of[i]), 32'd0);
            chk($sformatf("rst_rdy%0d", i), 32'(ir[i]), 32'd1);
        end

        // Directed scenarios, observed on the STAGES=2 instance
        @(negedge clk); rst = 1'b0; drive(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0); #1;
        chk("lat_early", 32'(ov[1]), 32'd0);
        @(negedge clk); drive(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0); #1;
        chk_res("ff_plus_1", 8'h00, 1'b1, 1'b0);
        @(negedge clk); drive(1'b1, 8'h05, 8'h07, 1'b1, 1'b1); #1;
        chk("bubble1", 32'(ov[1]), 32'd0);
        @(negedge clk); drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0); #1;
        chk_res("7f_plus_1", 8'h80, 1'b0, 1'b1);
        @(negedge clk); drive(1'b1, 8'h0F, 8'h01, 1'b0, 1'b0); #1;
        chk_res("5_minus_7", 8'hFE, 1'b0, 1'b0);
        @(negedge clk); drive(1'b1, 8'hF0, 8'h10, 1'b0, 1'b0); #1;
        chk("bubble2", 32'(ov[1]), 32'd0);
        @(negedge clk); drive(1'b1, 8'h11, 8'h22, 1'b0, 1'b0); #1;
        chk_res("b2b_first", 8'h10, 1'b0, 1'b0);
        @(negedge clk); drive(1'b1, 8'h33, 8'h44, 1'b0, 1'b0); #1;
        chk_res("b2b_second", 8'h00, 1'b1, 1'b0);

        // Stall: three cycles with out_ready low while a new operand waits
        @(negedge clk); drive(1'b1, 8'h55, 8'h01, 1'b0, 1'b0); out_ready = 1'b0; #1;
        chk_res("stall0", 8'h33, 1'b0, 1'b0);
        chk("stall0_rdy", 32'(ir[1]), 32'd0);
        for (int s = 1; s < 3; s++) begin
            @(negedge clk); #1;
            chk_res($sformatf("stall%0d", s), 8'h33, 1'b0, 1'b0);
            chk($sformatf("stall%0d_rdy", s), 32'(ir[1]), 32'd0);
        end
        @(negedge clk); out_ready = 1'b1; #1;
        chk_res("release", 8'h33, 1'b0, 1'b0);
        chk("release_rdy", 32'(ir[1]), 32'd1);
        @(negedge clk); drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0); #1;
        chk_res("drain1", 8'h77, 1'b0, 1'b0);
        @(negedge clk); #1;
        chk_res("drain2", 8'h56, 1'b0, 1'b0);
        @(negedge clk); #1;
        chk("drain_empty", 32'(ov[1]), 32'd0);

        // Asynchronous reset with a transaction in flight
        @(negedge clk); drive(1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        #2; rst = 1'b1; #1;
        chk("arst_vld", 32'(ov[1]), 32'd0);
        chk("arst_sum", 32'(sm[1]), 32'd0);
        chk("arst_rdy", 32'(ir[1]), 32'd1);
        @(negedge clk); rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk); #1;
            chk($sformatf("post_rst%0d", s), 32'(ov[1]), 32'd0);
        end

        // Random traffic on all instances, in-order scoreboard per instance
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            drive($urandom_range(0, 9) < 7, W'($urandom), W'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (ov[i] && out_ready) begin
                    if (exq[i].size() == 0) begin
                        chk($sformatf("rnd_extra%0d", i), 32'(ov[i]), 32'd0);
                    end else begin
                        e = exq[i].pop_front();
                        chk($sformatf("rnd%0d", i), 32'({of[i], cy[i], sm[i]}), 32'(e));
                    end
                end
                if (in_valid && ir[i]) exq[i].push_back(ref_add(a, b, carry_in, sub));
            end
        end

        @(negedge clk); drive(1'b0, '0, '0, 1'b0, 1'b0); out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            for (int i = 0; i < 4; i++) begin
                if (ov[i]) begin
                    if (exq[i].size() == 0) begin
                        chk($sformatf("drn_extra%0d", i), 32'(ov[i]), 32'd0);
                    end else begin
                        e = exq[i].pop_front();
                        chk($sformatf("drn%0d", i), 32'({of[i], cy[i], sm[i]}), 32'(e));
                    end
                end
            end
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("left_over%0d", i), 32'(exq[i].size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand and sum width in bits.
REQ-002 SHALL have parameter STAGES, default 2, meaning number of pipeline register stages, 1 <= STAGES <= WIDTH.
REQ-003 SHALL treat WIDTH % STAGES != 0 as an elaboration error; CHUNK = WIDTH/STAGES.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  operands present.
REQ-007 SHALL have port in_ready  output  1  operands accepted this cycle when in_valid=1.
REQ-008 SHALL have port a  input  WIDTH  operand A.
REQ-009 SHALL have port b  input  WIDTH  operand B.
REQ-010 SHALL have port carry_in  input  1  carry into bit 0; ignored when sub=1.
REQ-011 SHALL have port sub  input  1  0 = A+B+carry_in, 1 = A-B.
REQ-012 SHALL have port out_valid  output  1  result present.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port sum  output  WIDTH  result bits.
REQ-015 SHALL have port carry  output  1  carry out of MSB (sub: 1 = no borrow).
REQ-016 SHALL have port overflow  output  1  two's-complement signed overflow.

Function
REQ-017 SHALL split the add into STAGES chunks of CHUNK bits; stage k adds chunk k using the registered carry from stage k-1.
REQ-018 SHALL delay not-yet-added operand chunks and already-computed sum chunks alongside, so each transaction stays aligned.
REQ-019 SHALL for sub=1 add ~b with carry into bit 0 forced to 1.
REQ-020 SHALL compute carry as the carry out of bit WIDTH-1 and overflow as carry into MSB XOR carry out of MSB.
REQ-021 SHALL produce results modulo 2^WIDTH, with no truncation of the carry.
REQ-022 SHALL have latency exactly STAGES cycles from acceptance (in_valid & in_ready at a clock edge) to out_valid, absent stalls.
REQ-023 SHALL define advance = !(out_valid & !out_ready); all stage registers and per-stage valid bits update only when advance=1.
REQ-024 SHALL drive in_ready = advance (combinational from out_valid and out_ready only, not from in_valid).
REQ-025 SHALL insert a bubble (valid bit 0) into stage 0 when advance=1 and in_valid=0; bubbles are not collapsed.
REQ-026 SHALL sustain one transaction per cycle when out_ready is held 1.
REQ-027 SHALL hold sum, carry, overflow and out_valid stable while out_valid=1 and out_ready=0.
REQ-028 SHALL not lose, duplicate or reorder transactions under any in_valid/out_ready pattern.
REQ-029 SHALL when STAGES=1 register the full-width add once (latency 1).
REQ-030 SHALL leave sum/carry/overflow undefined-but-stable when out_valid=0; the bench checks them only when out_valid=1.

Reset
REQ-031 SHALL on rst=1 immediately clear all per-stage valid bits, out_valid=0, sum=0, carry=0, overflow=0, regardless of clk.
REQ-032 SHALL drop all in-flight transactions on reset mid-operation; none emerge after reset.
REQ-033 SHALL give in_ready=1 during and after reset (pipeline empty).
REQ-034 SHALL accept a transaction on the first rising edge after rst falls.

Verification (WIDTH=8, STAGES=2)
REQ-035 SHALL pass: a=0xFF, b=0x01, carry_in=0, sub=0, out_ready=1 -> 2 cycles later sum=0x00, carry=1, overflow=0.
REQ-036 SHALL pass: a=0x7F, b=0x01, sub=0 -> sum=0x80, carry=0, overflow=1; a=0x05, b=0x07, sub=1 -> sum=0xFE, carry=0, overflow=0.
REQ-037 SHALL pass: back-to-back 0x0F+0x01 then 0xF0+0x10 with out_ready=1 -> out_valid on consecutive cycles, sum=0x10/carry=0 then sum=0x00/carry=1.
REQ-038 SHALL pass: first result pending with out_ready=0 for 3 cycles -> in_ready=0, outputs frozen; out_ready=1 -> queued results drain in order.
REQ-039 SHALL pass: rst asserted between clock edges one cycle after acceptance -> out_valid=0 and sum=0 at once; no result appears afterward.
REQ-040 SHALL pass: 10^4 random operands, random in_valid/out_ready, STAGES in {1,2,4,8} -> every result matches a reference model in order.
